// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, issues word addresses to a 1-cycle memory,
// and buffers fetched {pc, instr} pairs in a 2-entry FIFO toward decode.
`default_nettype none

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_address,
    input  logic [31:0] mem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc
);

    logic [31:0] fetch_pc_q,    fetch_pc_d;
    logic        inflight_q,    inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [31:0] head_pc_q,     head_pc_d;
    logic [31:0] head_instr_q,  head_instr_d;
    logic [31:0] tail_pc_q,     tail_pc_d;
    logic [31:0] tail_instr_q,  tail_instr_d;
    logic [1:0]  count_q,       count_d;

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;
    logic [1:0]  remaining;

    assign pc_address     = fetch_pc_q;
    assign if_valid       = (count_q != 2'd0);
    assign if_pc          = head_pc_q;
    assign if_instruction = head_instr_q;

    always_comb begin
        pop       = if_valid && if_ready;
        // Slots that will be committed after this edge's pop; issue only if one is free.
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (occupancy < 3'd2) && !redirect_valid;
        push      = inflight_q && !redirect_valid;
        remaining = count_q - {1'b0, pop};

        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        head_pc_d     = head_pc_q;
        head_instr_d  = head_instr_q;
        tail_pc_d     = tail_pc_q;
        tail_instr_d  = tail_instr_q;
        count_d       = count_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            inflight_d = 1'b0;
            count_d    = 2'd0;
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + PC_STEP;
            end else begin
                inflight_d    = 1'b0;
            end

            if (pop) begin
                head_pc_d    = tail_pc_q;
                head_instr_d = tail_instr_q;
            end

            if (push) begin
                if (remaining == 2'd0) begin
                    head_pc_d    = inflight_pc_q;
                    head_instr_d = mem_instruction;
                end else begin
                    tail_pc_d    = inflight_pc_q;
                    tail_instr_d = mem_instruction;
                end
            end

            count_d = remaining + {1'b0, push};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
            head_pc_q     <= 32'd0;
            head_instr_q  <= 32'd0;
            tail_pc_q     <= 32'd0;
            tail_instr_q  <= 32'd0;
            count_q       <= 2'd0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_pc_q     <= head_pc_d;
            head_instr_q  <= head_instr_d;
            tail_pc_q     <= tail_pc_d;
            tail_instr_q  <= tail_instr_d;
            count_q       <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a registered word-indexed memory model.
`default_nettype none

module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pc_address;
    logic [31:0] mem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_address      (pc_address),
        .mem_instruction (mem_instruction),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instruction  (if_instruction),
        .if_pc           (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   mem_word = 32'h0000_0011;
            32'd1:   mem_word = 32'h0000_0022;
            32'd2:   mem_word = 32'h0000_0033;
            32'd3:   mem_word = 32'h0000_0044;
            default: mem_word = a ^ 32'h5A5A_0000;
        endcase
    endfunction

    always @(posedge clk) mem_instruction <= mem_word(pc_address);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
        chk({tag, "_pc"}, if_pc, pc);
        chk({tag, "_instr"}, if_instruction, mem_word(pc));
    endtask

    task automatic expect_empty(input string tag);
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        if_ready        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        #1 reset = 1'b0;
        #1;
        chk("rst_pc_address", pc_address, 32'h0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instruction, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        tick();
        chk("rst_hold_pc_address", pc_address, 32'h0);
        reset = 1'b1;

        // Reset start: two-edge latency, then one instruction per cycle
        tick();
        expect_empty("start_e1");
        chk("start_e1_pc_address", pc_address, 32'd1);
        tick(); expect_head("start_0", 32'd0);
        tick(); expect_head("start_1", 32'd1);
        tick(); expect_head("start_2", 32'd2);
        tick(); expect_head("start_3", 32'd3);
        chk("start_pc_address", pc_address, 32'd5);

        // Backpressure for 5 cycles: head and pc_address hold
        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_head("bp_hold", 32'd3);
            chk("bp_pc_address", pc_address, 32'd5);
        end
        if_ready = 1'b1;
        tick(); expect_head("bp_rel_4", 32'd4);
        tick(); expect_head("bp_rel_5", 32'd5);

        // Redirect in the same cycle as the handshake on pc 5
        redirect_valid  = 1'b1;
        redirect_target = 32'h10;
        tick();
        redirect_valid  = 1'b0;
        expect_empty("rdpop_gap0");
        chk("rdpop_pc_address", pc_address, 32'h10);
        tick(); expect_empty("rdpop_gap1");
        tick(); expect_head("rdpop_10", 32'h10);
        tick(); expect_head("rdpop_11", 32'h11);

        // Fill the buffer, then redirect while stalled
        if_ready = 1'b0;
        tick(); expect_head("full_hold", 32'h11);
        chk("full_pc_address", pc_address, 32'h13);
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        tick();
        redirect_valid  = 1'b0;
        if_ready        = 1'b1;
        expect_empty("rdfull_gap0");
        chk("rdfull_pc_address", pc_address, 32'h40);
        tick(); expect_empty("rdfull_gap1");
        tick(); expect_head("rdfull_40", 32'h40);
        tick(); expect_head("rdfull_41", 32'h41);

        // Back-to-back redirects: the second wins
        redirect_valid  = 1'b1;
        redirect_target = 32'h20;
        tick();
        redirect_target = 32'h30;
        tick();
        redirect_valid  = 1'b0;
        expect_empty("b2b_gap0");
        chk("b2b_pc_address", pc_address, 32'h30);
        tick(); expect_empty("b2b_gap1");
        tick(); expect_head("b2b_30", 32'h30);
        tick(); expect_head("b2b_31", 32'h31);

        // Redirect to the top of the address space: PC wraps to 0
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        tick();
        redirect_valid  = 1'b0;
        expect_empty("wrap_gap0");
        tick();
        expect_empty("wrap_gap1");
        chk("wrap_pc_address", pc_address, 32'h0);
        tick(); expect_head("wrap_ffff", 32'hFFFF_FFFF);
        tick(); expect_head("wrap_0", 32'h0);
        tick(); expect_head("wrap_1", 32'h1);

        // Half-cycle asynchronous reset pulse between edges
        #1 reset = 1'b0;
        #1;
        chk("arst_pc_address", pc_address, 32'h0);
        chk("arst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("arst_if_instr", if_instruction, 32'h0);
        chk("arst_if_pc", if_pc, 32'h0);
        #4 reset = 1'b1;
        tick();
        expect_empty("arst_e1");
        chk("arst_e1_pc_address", pc_address, 32'd1);
        tick(); expect_head("arst_0", 32'd0);
        tick(); expect_head("arst_1", 32'd1);
        tick(); expect_head("arst_2", 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
